parity_check: RTL and testbench
===============================

Name: parity_check

Overview:
- Registered 3-input parity checker.
- Each clock samples the data bits x, y, z and flags a parity violation on `result` one cycle later.
- A saturating violation counter is kept for status and debug.
- Sits as a leaf checker beside a 3-bit data/parity bus (two data bits plus one parity bit).

Parameters:
- ODD_PARITY, 0, parity convention. 0 = even parity: a word is good when its count of 1s is even. 1 = odd parity: a word is good when its count of 1s is odd.
- CNT_W, 8, width of the violation counter `err_cnt`. Legal range is 1..32.

Ports:
- clk  input  1  rising-edge clock.
- n_rst  input  1  asynchronous reset, active-high. When n_rst=1, all state clears immediately.
- x  input  1  bit 0 of the checked word.
- y  input  1  bit 1 of the checked word.
- z  input  1  bit 2 of the checked word (the parity bit).
- result  output  1  registered violation flag. 1 means the word sampled at the previous edge violated the selected parity.
- err_cnt  output  CNT_W  saturating count of violations since reset.

Behaviour:
- Combinational parity: p = x ^ y ^ z. The violation signal is v = p ^ ODD_PARITY.
  - Even mode (ODD_PARITY=0): v = p.
  - Odd mode (ODD_PARITY=1): v = ~p.
- Registers: result <= v on every rising clk edge while n_rst=0. There is no enable.
- Latency: exactly 1 cycle. Inputs are sampled at edge N, and `result` reflects them after edge N.
- State machine, 2 states:
  - States: GOOD (result=0) and BAD (result=1).
  - Next state is BAD when v=1, else GOOD.
  - The state register is the `result` flop; no other state exists.
- Counter: err_cnt <= err_cnt + 1 on each edge where v=1. It saturates at all-ones and never wraps.
- Reset: n_rst=1 asynchronously forces result=0 (state GOOD) and err_cnt=0.
- Reset release: the first edge with n_rst=0 samples x/y/z normally.
- Reset mid-operation: outputs clear within the same cycle, without waiting for an edge. The counter restarts from 0.
- X/Z on inputs: undefined result. The verification bench must drive known values.
- Inputs are assumed synchronous to clk. No synchronizer is included.

Optional Feature:
- Macro PARITY_CHECK_STICKY_EN.
- When defined:
  - Adds output port `sticky_err` (1 bit).
  - sticky_err is set on the first edge where v=1 and holds at 1 until reset.
  - Its reset value is 0.
- When undefined: the port and its flop are absent, and all other behaviour is identical.

Decomposition:
- Package parity_check_pkg holds:
  - Constants PAR_EVEN=0 and PAR_ODD=1.
  - The state encoding GOOD=1'b0 / BAD=1'b1.
  - A default CNT_W constant of 8.
- One sub-module, parity3_calc: purely combinational, taking x, y, z and an odd-mode select, producing v.
- The top module holds all flops and the counter.

Test Plan (even mode, CNT_W=8):
- Reset held for 10 time units with xyz=000, then released -> result=0 and err_cnt=0 during and after reset; after the next edge, result=0.
- xyz=001 applied for 2 cycles -> after the first edge result=1 and err_cnt=1; after the second edge err_cnt=2.
- xyz=011 -> after the next edge result=0 and err_cnt is unchanged.
- xyz=010 -> after the next edge result=1 and err_cnt increments.
- n_rst asserted mid-cycle while result=1 and err_cnt=3 -> result=0 and err_cnt=0 immediately, before any clk edge.
- Odd mode (ODD_PARITY=1), xyz=000 -> result=1 after the edge. With CNT_W=2 and 5 consecutive violations, err_cnt holds at 3. With PARITY_CHECK_STICKY_EN defined, sticky_err stays 1 once set.

Source files
------------

// File: rtl/parity_check_pkg.sv
// Shared constants and state encoding for the parity_check leaf checker.
package parity_check_pkg;

  localparam int PAR_EVEN  = 0;
  localparam int PAR_ODD   = 1;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    GOOD = 1'b0,
    BAD  = 1'b1
  } state_t;

endpackage

// File: rtl/parity3_calc.sv
// Combinational 3-bit parity violation detector; odd=1 selects odd parity.
module parity3_calc (
  input  logic x,
  input  logic y,
  input  logic z,
  input  logic odd,
  output logic v
);

  assign v = x ^ y ^ z ^ odd;

endmodule

// File: rtl/parity_check.sv
// Registered 3-input parity checker with a saturating violation counter.
// Optional sticky violation flag enabled by defining PARITY_CHECK_STICKY_EN.
module parity_check
  import parity_check_pkg::*;
#(
  parameter int ODD_PARITY = PAR_EVEN,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  output logic             result,
  output logic [CNT_W-1:0] err_cnt
`ifdef PARITY_CHECK_STICKY_EN
  ,
  output logic             sticky_err
`endif
);

  localparam logic ODD_SEL = (ODD_PARITY != PAR_EVEN);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic             v_p0;
  state_t           state_p1;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_p1;

  parity3_calc u_calc (
    .x   (x),
    .y   (y),
    .z   (z),
    .odd (ODD_SEL),
    .v   (v_p0)
  );

  // Stage p0 -> p1: n_rst is an active-high asynchronous clear despite its name
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_p1 <= GOOD;
      cnt_p1   <= '0;
    end else begin
      state_p1 <= state_nxt;
      if (v_p0) cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  always_comb begin
    state_nxt = GOOD;
    if (v_p0) state_nxt = BAD;
  end

  always_comb begin
    result = (state_p1 == BAD);
  end

  assign err_cnt = cnt_p1;

`ifdef PARITY_CHECK_STICKY_EN
  logic sticky_p1;

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst)     sticky_p1 <= 1'b0;
    else if (v_p0) sticky_p1 <= 1'b1;
  end

  assign sticky_err = sticky_p1;
`endif

endmodule

// File: tb/tb_parity_check.sv
// Self-checking bench: even-mode (CNT_W=8) and odd-mode (CNT_W=2) instances
// driven in lockstep; a scoreboard model predicts result/err_cnt/sticky_err.
module tb_parity_check;

  logic       clk = 1'b0;
  logic       rst;
  logic       x, y, z;
  logic       result_e, result_o;
  logic [7:0] err_cnt_e;
  logic [1:0] err_cnt_o;
`ifdef PARITY_CHECK_STICKY_EN
  logic       sticky_e, sticky_o;
`endif

  int total = 0;
  int bad   = 0;

  int   m_cnt_e, m_cnt_o;
  logic m_stk_e, m_stk_o;
  logic [8:0] q_e[$];
  logic [2:0] q_o[$];

  always #5 clk = ~clk;

  parity_check #(.ODD_PARITY(0), .CNT_W(8)) dut_e (
    .clk(clk), .n_rst(rst), .x(x), .y(y), .z(z),
    .result(result_e), .err_cnt(err_cnt_e)
`ifdef PARITY_CHECK_STICKY_EN
    , .sticky_err(sticky_e)
`endif
  );

  parity_check #(.ODD_PARITY(1), .CNT_W(2)) dut_o (
    .clk(clk), .n_rst(rst), .x(x), .y(y), .z(z),
    .result(result_o), .err_cnt(err_cnt_o)
`ifdef PARITY_CHECK_STICKY_EN
    , .sticky_err(sticky_o)
`endif
  );

  task automatic model_clear();
    m_cnt_e = 0; m_cnt_o = 0;
    m_stk_e = 1'b0; m_stk_o = 1'b0;
    q_e.delete(); q_o.delete();
  endtask

  // Drive one word at the falling edge, push predictions, wait past the rising edge.
  task automatic drive(input logic xv, input logic yv, input logic zv);
    logic ve, vo;
    @(negedge clk);
    x = xv; y = yv; z = zv;
    ve = (xv + yv + zv) % 2 == 1;
    vo = !ve;
    if (ve && m_cnt_e < 255) m_cnt_e++;
    if (vo && m_cnt_o < 3) m_cnt_o++;
    m_stk_e = m_stk_e | ve;
    m_stk_o = m_stk_o | vo;
    q_e.push_back({ve, 8'(m_cnt_e)});
    q_o.push_back({vo, 2'(m_cnt_o)});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; x = 0; y = 0; z = 0;
    model_clear();
    #2;
    total++;
    if ({result_e, err_cnt_e, result_o, err_cnt_o} !== 12'h000) begin
      bad++;
      $display("FAIL reset_hold got=%h want=000", {result_e, err_cnt_e, result_o, err_cnt_o});
    end
    #8 rst = 1'b0;
    #1;
    total++;
    if ({result_e, err_cnt_e} !== 9'h000) begin
      bad++;
      $display("FAIL reset_release got=%h want=000", {result_e, err_cnt_e});
    end
    drive(0, 0, 0);
    total++;
    if ({result_e, err_cnt_e} !== q_e.pop_front()) begin
      bad++;
      $display("FAIL reset_first_edge got=%h want=000", {result_e, err_cnt_e});
    end
    void'(q_o.pop_front());
  endtask

  task automatic test_even_words();
    logic [2:0] words[4] = '{3'b001, 3'b001, 3'b011, 3'b010};
    logic [8:0] exp;
    foreach (words[i]) begin
      drive(words[i][2], words[i][1], words[i][0]);
      exp = q_e.pop_front();
      total++;
      if ({result_e, err_cnt_e} !== exp) begin
        bad++;
        $display("FAIL even_word%0d got res=%b cnt=%0d want res=%b cnt=%0d",
                 i, result_e, err_cnt_e, exp[8], exp[7:0]);
      end
      void'(q_o.pop_front());
    end
    total++;
    if (err_cnt_e !== 8'd3) begin
      bad++;
      $display("FAIL even_cnt_total got=%0d want=3", err_cnt_e);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({result_e, err_cnt_e} !== 9'h000) begin
      bad++;
      $display("FAIL reset_mid_async got res=%b cnt=%0d want res=0 cnt=0", result_e, err_cnt_e);
    end
    model_clear();
    @(posedge clk);
    #1;
    total++;
    if ({result_e, err_cnt_e, result_o, err_cnt_o} !== 12'h000) begin
      bad++;
      $display("FAIL reset_mid_held got=%h want=000", {result_e, err_cnt_e, result_o, err_cnt_o});
    end
    rst = 1'b0;
  endtask

  task automatic test_odd_sat();
    logic [2:0] exp;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) drive(0, 0, 0);
      else       drive(1, 1, 1);
      void'(q_e.pop_front());
      exp = q_o.pop_front();
      total++;
      if ({result_o, err_cnt_o} !== exp) begin
        bad++;
        $display("FAIL odd_step%0d got res=%b cnt=%0d want res=%b cnt=%0d",
                 i, result_o, err_cnt_o, exp[2], exp[1:0]);
      end
    end
    total++;
    if (err_cnt_o !== 2'd3) begin
      bad++;
      $display("FAIL odd_saturate got=%0d want=3", err_cnt_o);
    end
`ifdef PARITY_CHECK_STICKY_EN
    total++;
    if ({sticky_e, sticky_o} !== {m_stk_e, m_stk_o}) begin
      bad++;
      $display("FAIL sticky_hold got=%b%b want=%b%b", sticky_e, sticky_o, m_stk_e, m_stk_o);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_e;
    logic [2:0] exp_o;
    logic [2:0] w;
    for (int i = 0; i < 300; i++) begin
      w = 3'($urandom_range(0, 7));
      drive(w[2], w[1], w[0]);
      if (q_e.size() == 0 || q_o.size() == 0) begin
        total++; bad++;
        $display("FAIL b2b_queue_empty step=%0d got=empty want=entry", i);
        continue;
      end
      exp_e = q_e.pop_front();
      exp_o = q_o.pop_front();
      total++;
      if ({result_e, err_cnt_e} !== exp_e) begin
        bad++;
        $display("FAIL b2b_even step=%0d got=%h want=%h", i, {result_e, err_cnt_e}, exp_e);
      end
      total++;
      if ({result_o, err_cnt_o} !== exp_o) begin
        bad++;
        $display("FAIL b2b_odd step=%0d got=%h want=%h", i, {result_o, err_cnt_o}, exp_o);
      end
`ifdef PARITY_CHECK_STICKY_EN
      total++;
      if ({sticky_e, sticky_o} !== {m_stk_e, m_stk_o}) begin
        bad++;
        $display("FAIL b2b_sticky step=%0d got=%b%b want=%b%b",
                 i, sticky_e, sticky_o, m_stk_e, m_stk_o);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_even_words();
    test_reset_mid();
    test_odd_sat();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
